// File: rtl/spi_regbank_pkg.sv
// Shared definitions for the SPI slave register bank: FSM encoding, command
// field positions and the wrapped address increment.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        StCmd   = 2'd0,
        StWdata = 2'd1,
        StRdata = 2'd2
    } state_e;

    // Command frame: top bit is W (1 write, 0 read), next bit is INC.
    function automatic int unsigned w_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

    function automatic int unsigned inc_bit(input int unsigned data_w);
        return data_w - 2;
    endfunction

    // Next address; the last register and any out-of-range address both wrap to 0.
    function automatic int unsigned addr_inc(input int unsigned addr, input int unsigned num_regs);
        return (addr >= num_regs - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Per-frame bit counter, MOSI deserialiser and MISO serialiser.
// The MISO serialiser exists only when SPI_REGBANK_READBACK_EN is defined;
// otherwise tx_bit_o is tied low.
module spi_frame_shifter #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              SPI_clk_x,
    input  logic              frame_clr_ni,
    input  logic              mosi_i,
    input  logic              tx_load_i,
    input  logic [DATA_W-1:0] tx_word_i,
    output logic [DATA_W-1:0] rx_word_o,
    output logic              frame_done_o,
    output logic              tx_bit_o
);
    localparam int unsigned CntW = $clog2(DATA_W);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    // rx_d is the word as it stands once the current MOSI bit is taken in.
    always_comb begin
        frame_done_o = (cnt_q == CntW'(DATA_W - 1));
        cnt_d        = frame_done_o ? '0 : cnt_q + 1'b1;
        if (MSB_FIRST) begin
            rx_d = {rx_q[DATA_W-2:0], mosi_i};
        end else begin
            rx_d = {mosi_i, rx_q[DATA_W-1:1]};
        end
        rx_word_o = rx_d;
    end

    // Counter and receive shifter, cleared whenever the frame is aborted.
    always_ff @(posedge SPI_clk_x or negedge frame_clr_ni) begin
        if (!frame_clr_ni) begin
            cnt_q <= '0;
            rx_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rx_q  <= rx_d;
        end
    end

`ifdef SPI_REGBANK_READBACK_EN
    logic [DATA_W-1:0] tx_q;

    // Transmit shifter: a load takes priority over the per-bit shift.
    always_ff @(posedge SPI_clk_x or negedge frame_clr_ni) begin
        if (!frame_clr_ni) begin
            tx_q <= '0;
        end else if (tx_load_i) begin
            tx_q <= tx_word_i;
        end else if (MSB_FIRST) begin
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end else begin
            tx_q <= {1'b0, tx_q[DATA_W-1:1]};
        end
    end

    assign tx_bit_o = MSB_FIRST ? tx_q[DATA_W-1] : tx_q[0];
`else
    logic unused_tx;
    assign unused_tx = ^{tx_load_i, tx_word_i};
    assign tx_bit_o  = 1'b0;
`endif

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave (mode 0) register bank: a command frame selects read/write,
// auto-increment and start address, followed by any number of data frames.
// Optional MISO readback is enabled by defining SPI_REGBANK_READBACK_EN.
module spi_slave_regbank
    import spi_regbank_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       SPI_clk_x,
    input  logic                       HRESETn,
    input  logic                       spi_ss_i,
    input  logic                       spi_mosi_i,
    output logic                       spi_miso_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_stb_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int unsigned WBit   = w_bit(DATA_W);
    localparam int unsigned IncBit = inc_bit(DATA_W);

    logic                frame_clr_n;
    logic [DATA_W-1:0]   rx_word, tx_word;
    logic                frame_done, tx_load, tx_bit;
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, next_addr, tx_addr;
    logic                inc_q, inc_d;
    logic                commit, rd_access;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                wr_stb_q, err_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Deasserted slave select aborts the transaction exactly like a reset.
    assign frame_clr_n = HRESETn & ~spi_ss_i;

    spi_frame_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .SPI_clk_x    (SPI_clk_x),
        .frame_clr_ni (frame_clr_n),
        .mosi_i       (spi_mosi_i),
        .tx_load_i    (tx_load),
        .tx_word_i    (tx_word),
        .rx_word_o    (rx_word),
        .frame_done_o (frame_done),
        .tx_bit_o     (tx_bit)
    );

    assign next_addr = ADDR_W'(addr_inc(32'(addr_q), NUM_REGS));

    // Frame-level FSM and address sequencing; all actions happen on the last bit of a frame.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inc_d     = inc_q;
        commit    = 1'b0;
        tx_load   = 1'b0;
        rd_access = 1'b0;
        tx_addr   = addr_q;
        if (frame_done) begin
            case (state_q)
                StCmd: begin
                    inc_d  = rx_word[IncBit];
                    addr_d = rx_word[ADDR_W-1:0];
                    if (rx_word[WBit]) begin
                        state_d = StWdata;
                    end else begin
                        state_d   = StRdata;
                        tx_load   = 1'b1;
                        rd_access = 1'b1;
                        tx_addr   = rx_word[ADDR_W-1:0];
                    end
                end
                StWdata: begin
                    commit = 1'b1;
                    if (inc_q) addr_d = next_addr;
                end
                StRdata: begin
                    if (inc_q) addr_d = next_addr;
                    tx_load   = 1'b1;
                    rd_access = 1'b1;
                    tx_addr   = inc_q ? next_addr : addr_q;
                end
                default: state_d = StCmd;
            endcase
        end
        tx_word = in_range(tx_addr) ? regs_q[tx_addr] : '0;
    end

    // Transaction state, cleared at every slave-select deassertion.
    always_ff @(posedge SPI_clk_x or negedge frame_clr_n) begin
        if (!frame_clr_n) begin
            state_q <= StCmd;
            addr_q  <= '0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
        end
    end

    // Register file, write strobe and sticky error survive slave-select cycles.
    always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_stb_q <= commit & in_range(addr_q);
            if (commit && in_range(addr_q)) begin
                regs_q[addr_q] <= rx_word;
                wr_addr_q      <= addr_q;
                wr_data_q      <= rx_word;
            end
            if ((commit && !in_range(addr_q)) || (rd_access && !in_range(tx_addr))) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign spi_miso_o = (state_q == StRdata) & tx_bit;
    assign wr_stb_o   = wr_stb_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = (state_q != StCmd);
    assign err_o      = err_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench: an 8-register instance for the main flows and a 6-register
// instance for out-of-range handling, sharing clock, reset and MOSI.
module tb_spi_slave_regbank;

    logic        clk = 1'b0;
    logic        rst_n, ss, ss6, mosi;
    logic        miso, stb, busy, err;
    logic [63:0] regs;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic        miso6, stb6, busy6, err6;
    logic [47:0] regs6;
    logic [2:0]  waddr6;
    logic [7:0]  wdata6;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] stb_log[$];
    int          stb6_cnt = 0;

`ifdef SPI_REGBANK_READBACK_EN
    localparam logic [7:0] ExpRd0 = 8'h22;
`else
    localparam logic [7:0] ExpRd0 = 8'h00;
`endif

    always #5 clk = ~clk;

    spi_slave_regbank dut (
        .SPI_clk_x  (clk),
        .HRESETn    (rst_n),
        .spi_ss_i   (ss),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .regs_o     (regs),
        .wr_stb_o   (stb),
        .wr_addr_o  (waddr),
        .wr_data_o  (wdata),
        .busy_o     (busy),
        .err_o      (err)
    );

    spi_slave_regbank #(
        .NUM_REGS (6)
    ) dut6 (
        .SPI_clk_x  (clk),
        .HRESETn    (rst_n),
        .spi_ss_i   (ss6),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso6),
        .regs_o     (regs6),
        .wr_stb_o   (stb6),
        .wr_addr_o  (waddr6),
        .wr_data_o  (wdata6),
        .busy_o     (busy6),
        .err_o      (err6)
    );

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (stb) stb_log.push_back({waddr, wdata});
        if (stb6) stb6_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One MSB-first frame; MISO is sampled at the negedge before each sampling posedge.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi  = tx[i];
            rx[i] = miso;
            @(negedge clk);
        end
    endtask

    task automatic start(input bit six);
        @(negedge clk);
        if (six) ss6 = 1'b0;
        else ss = 1'b0;
    endtask

    task automatic stop();
        ss  = 1'b1;
        ss6 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] reg8(input int n);
        return 64'(regs[n*8 +: 8]);
    endfunction

    logic [7:0] rx, r1, r2;

    initial begin
        rst_n = 1'b0;
        ss    = 1'b1;
        ss6   = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_regs", regs, 64'h0);
        check_eq("rst_flags", {60'h0, stb, busy, err, miso}, 64'h0);
        check_eq("rst_wr", {53'h0, waddr, wdata}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Burst write with increment from 0.
        stb_log.delete();
        start(0);
        xfer(8'hC0, rx);
        xfer(8'h11, rx);
        check_eq("wr_busy", 64'(busy), 64'h1);
        xfer(8'h22, rx);
        check_eq("wr_miso", 64'(rx), 64'h0);
        stop();
        check_eq("bw_reg0", reg8(0), 64'h11);
        check_eq("bw_reg1", reg8(1), 64'h22);
        check_eq("bw_cnt", 64'(stb_log.size()), 64'd2);
        if (stb_log.size() == 2) begin
            check_eq("bw_stb0", 64'(stb_log[0]), 64'h011);
            check_eq("bw_stb1", 64'(stb_log[1]), 64'h122);
        end
        check_eq("idle_busy", 64'(busy), 64'h0);

        // Increment wraps from the last register to 0.
        stb_log.delete();
        start(0);
        xfer(8'hC7, rx);
        xfer(8'hAA, rx);
        xfer(8'hBB, rx);
        stop();
        check_eq("wrap_reg7", reg8(7), 64'hAA);
        check_eq("wrap_reg0", reg8(0), 64'hBB);
        check_eq("wrap_err", 64'(err), 64'h0);
        check_eq("wrap_cnt", 64'(stb_log.size()), 64'd2);

        // No increment: both writes land on reg3.
        stb_log.delete();
        start(0);
        xfer(8'h83, rx);
        xfer(8'h01, rx);
        xfer(8'h02, rx);
        stop();
        check_eq("ninc_reg3", reg8(3), 64'h02);
        check_eq("ninc_reg4", reg8(4), 64'h00);
        check_eq("ninc_cnt", 64'(stb_log.size()), 64'd2);
        if (stb_log.size() == 2) begin
            check_eq("ninc_stb0", 64'(stb_log[0]), 64'h301);
            check_eq("ninc_stb1", 64'(stb_log[1]), 64'h302);
        end

        // Burst read from reg1: 0x22 then reg2 (never written).
        stb_log.delete();
        start(0);
        xfer(8'h41, rx);
        xfer(8'h00, r1);
        check_eq("rd_busy", 64'(busy), 64'h1);
        xfer(8'h00, r2);
        stop();
        check_eq("rd_byte0", 64'(r1), 64'(ExpRd0));
        check_eq("rd_byte1", 64'(r2), 64'h00);
        check_eq("rd_nostb", 64'(stb_log.size()), 64'd0);
        check_eq("rd_err", 64'(err), 64'h0);

        // Aborted partial command frame, then a clean write to reg5.
        stb_log.delete();
        start(0);
        for (int i = 7; i >= 3; i--) begin
            mosi = (i >= 6);
            @(negedge clk);
        end
        stop();
        start(0);
        xfer(8'hC5, rx);
        xfer(8'h5A, rx);
        stop();
        check_eq("abort_reg5", reg8(5), 64'h5A);
        check_eq("abort_reg0", reg8(0), 64'hBB);
        check_eq("abort_cnt", 64'(stb_log.size()), 64'd1);
        if (stb_log.size() == 1) check_eq("abort_stb", 64'(stb_log[0]), 64'h55A);

        // Out-of-range write on the 6-register instance.
        start(1);
        xfer(8'hC7, rx);
        xfer(8'h99, rx);
        stop();
        check_eq("oor_nostb", 64'(stb6_cnt), 64'd0);
        check_eq("oor_err", 64'(err6), 64'h1);
        check_eq("oor_regs", 64'(regs6), 64'h0);
        start(1);
        xfer(8'hC2, rx);
        xfer(8'h33, rx);
        stop();
        check_eq("oor_sticky", 64'(err6), 64'h1);
        check_eq("oor_reg2", 64'(regs6[16 +: 8]), 64'h33);
        check_eq("oor_cnt", 64'(stb6_cnt), 64'd1);

        // Reset pulse in the middle of a frame.
        start(1);
        xfer(8'hC1, rx);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_regs6", 64'(regs6), 64'h0);
        check_eq("mrst_regs", regs, 64'h0);
        check_eq("mrst_err6", 64'(err6), 64'h0);
        check_eq("mrst_miso6", 64'(miso6), 64'h0);
        check_eq("mrst_busy6", 64'(busy6), 64'h0);
        @(negedge clk);
        stop();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_regs6", 64'(regs6), 64'h0);
        check_eq("post_err6", 64'(err6), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regbank.md
Name: spi_slave_regbank

Overview:
- Parametrised SPI-slave register bank; successor to the fixed two-byte display SPI receiver.
- Decodes a command frame, then a burst of DATA_W-bit data frames, into a NUM_REGS-deep register file.
- Registers are exported in parallel to downstream logic (display digits, control bits); a read command returns register contents on MISO.
- Sits behind one slave-select line of the AHB SPI master; the whole block runs in the SPI clock domain.

Parameters:
- DATA_W, 8, bits per SPI frame (command and data); must be >= 8.
- NUM_REGS, 8, number of registers; need not be a power of 2.
- ADDR_W, 3, register address width; must satisfy ADDR_W <= DATA_W-2 and 2**ADDR_W >= NUM_REGS.
- MSB_FIRST, 1, 1 = frames shifted MSB first, 0 = LSB first.

Ports:
- SPI_clk_x  in  1  SPI clock from master, mode 0, all logic on posedge.
- HRESETn  in  1  reset.
- spi_ss_i  in  1  slave select, active low.
- spi_mosi_i  in  1  serial data in.
- spi_miso_o  out  1  serial data out.
- regs_o  out  NUM_REGS*DATA_W  flattened register file; reg n occupies bits [n*DATA_W +: DATA_W].
- wr_stb_o  out  1  one-cycle pulse per committed data write.
- wr_addr_o  out  ADDR_W  address of the committed write.
- wr_data_o  out  DATA_W  data of the committed write.
- busy_o  out  1  high while a transaction is past its command frame.
- err_o  out  1  sticky out-of-range address flag.

Interface note: reset HRESETn, asynchronous, active-low; clock SPI_clk_x.

Behaviour:
- Reset values: all registers, regs_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o, err_o and spi_miso_o are 0; FSM is in CMD.
- Frame clear: FSM, bit counter and shift registers are asynchronously cleared to CMD/0 while HRESETn is low OR spi_ss_i is high.
  - The register file and err_o are cleared only by HRESETn.
  - A partial frame is discarded with no write.
- Bit timing: MOSI is sampled on each posedge while spi_ss_i is low. The bit counter runs 0..DATA_W-1 and wraps to 0 at end of frame.
- Command frame (bits numbered in received order after assembly):
  - bit DATA_W-1 = W (1 write, 0 read).
  - bit DATA_W-2 = INC (auto-increment).
  - bits [ADDR_W-1:0] = start address.
  - Remaining bits are ignored.
- FSM:
  - CMD: on the last command bit, latch W, INC and address, then go to WDATA or RDATA. busy_o goes 1 in the same cycle.
  - WDATA: on the last bit of each frame, commit the assembled word to reg[addr].
    - Pulse wr_stb_o for 1 cycle, with wr_addr_o/wr_data_o valid in that cycle.
    - If INC, address advances; otherwise the same address is overwritten.
  - RDATA: shift out reg[addr]. At each frame end, advance the address if INC, then load the next word.
  - WDATA/RDATA persist for any number of frames until the frame clear. No transition back to CMD without SS deassertion.
- Address wrap: addr+1 wraps to 0 when addr == NUM_REGS-1.
- Out-of-range address (addr >= NUM_REGS, only possible when NUM_REGS is not a power of 2):
  - Write is dropped; no wr_stb_o pulse.
  - Read returns all zeros.
  - err_o is set and stays 1 until HRESETn.
  - An INC from an out-of-range address wraps to 0.
- MISO timing:
  - The shift register updates on posedge; bit k of a read frame is driven after posedge k-1 and held through posedge k.
  - The first read bit is driven after the final command-bit posedge.
  - spi_miso_o is 0 outside RDATA.
- Read of a register written earlier in the same transaction returns the new value; commit precedes load in the same cycle.
- MSB_FIRST applies identically to MOSI assembly and MISO shifting.

Optional Feature:
- Macro SPI_REGBANK_READBACK_EN.
- Defined: RDATA behaves as above.
- Undefined:
  - A read command still enters RDATA and advances the address per frame.
  - spi_miso_o is tied 0 and the MISO shift register is not synthesised.
  - err_o is still set on out-of-range reads.

Decomposition:
- Shared package spi_regbank_pkg holds:
  - FSM state encoding: CMD, WDATA, RDATA.
  - Command-field bit positions: W_BIT = DATA_W-1, INC_BIT = DATA_W-2.
  - A function for wrapped address increment.
- One sub-module, spi_frame_shifter: bit counter, MOSI deserialiser, MISO serialiser and frame-done pulse, with the frame-clear input.
- spi_slave_regbank holds the FSM, address logic and register file.

Test Plan (defaults DATA_W=8, NUM_REGS=8, MSB_FIRST=1, readback enabled unless stated):
- Burst write: SS low, send 0xC0, 0x11, 0x22, SS high → reg0=0x11, reg1=0x22; two wr_stb_o pulses with addr 0 then 1.
- Wrap: send 0xC7, 0xAA, 0xBB → reg7=0xAA, reg0=0xBB; err_o stays 0.
- Non-increment: send 0x83, 0x01, 0x02 → reg3=0x02; two wr_stb_o pulses, both with wr_addr_o=3.
- Burst read after the writes above: send 0x41, then 16 dummy clocks → MISO returns 0x22, then 0x00 (reg2).
- Abort: SS low, send 5 bits of 0xC0, SS high, then send 0xC5, 0x5A → no write from the aborted frame; reg5=0x5A.
- Out of range (NUM_REGS=6): send 0xC7, 0x99 → no wr_stb_o, err_o=1 and sticky; then HRESETn pulse mid-frame → all regs 0, err_o=0, spi_miso_o=0.
